conv_sched: RTL and testbench

- Layer-level scheduler that drives the convolution controller, one convolution instruction at a time.
- Accepts one layer descriptor per handshake: weight base, data base, picture size, and number of InputDim-channel groups.
- Splits the layer into per-group instructions with per-lane weight/data addresses and first/last flags.
- Toggles the instruction tag for each instruction and waits for the controller's finish before issuing the next; runs on the controller's main clock.

---
 rtl/conv_sched.sv | 202 ++++++++++++++++++++
 tb/tb_conv_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - layer scheduler issuing per-group convolution instructions
module conv_sched #(
  parameter int AddrWidth    = 32,
  parameter int PictWidth    = 9,
  parameter int GroupWidth   = 8,
  parameter int KernelSize   = 9,
  parameter int InputDim     = 4,
  parameter int TimeoutWidth = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AddrWidth-1:0]  cmd_weight_base,
  input  logic [AddrWidth-1:0]  cmd_data_base,
  input  logic [PictWidth-1:0]  cmd_pict_size,
  input  logic [GroupWidth-1:0] cmd_groups,
  input  logic                  conv_finish_in,
  output logic [AddrWidth-1:0]  weight_addr0_out,
  output logic [AddrWidth-1:0]  weight_addr1_out,
  output logic [AddrWidth-1:0]  weight_addr2_out,
  output logic [AddrWidth-1:0]  weight_addr3_out,
  output logic [AddrWidth-1:0]  data_addr0_out,
  output logic [AddrWidth-1:0]  data_addr1_out,
  output logic [AddrWidth-1:0]  data_addr2_out,
  output logic [AddrWidth-1:0]  data_addr3_out,
  output logic [PictWidth-1:0]  pict_size_out,
  output logic                  conv_first_out,
  output logic                  conv_last_out,
  output logic                  inst_tag_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [AddrWidth-1:0]    w_ptr_q, w_ptr_d;
  logic [AddrWidth-1:0]    d_ptr_q, d_ptr_d;
  logic [AddrWidth-1:0]    plane_q, plane_d;
  logic [GroupWidth-1:0]   grp_q, grp_d;
  logic [GroupWidth-1:0]   groups_q, groups_d;
  logic [PictWidth-1:0]    pict_q, pict_d;
  logic [TimeoutWidth-1:0] wdog_q, wdog_d;
  logic                    fin_prev_q, fin_prev_d;
  logic                    err_q, err_d;
  logic                    tag_q, tag_d;
  logic [AddrWidth-1:0]    waddr_q [4];
  logic [AddrWidth-1:0]    waddr_d [4];
  logic [AddrWidth-1:0]    daddr_q [4];
  logic [AddrWidth-1:0]    daddr_d [4];
  logic [PictWidth-1:0]    pict_out_q, pict_out_d;
  logic                    first_q, first_d;
  logic                    last_q, last_d;

  logic [TimeoutWidth-1:0] wdog_inc;
  logic                    last_grp;
  logic                    fin_rise;

  assign wdog_inc = wdog_q + TimeoutWidth'(1);
  assign last_grp = (grp_q == groups_q - GroupWidth'(1));
  assign fin_rise = conv_finish_in & ~fin_prev_q;

  // Next-state and datapath: one instruction per ISSUE, advance only on a finish rising edge
  always_comb begin
    state_d    = state_q;
    w_ptr_d    = w_ptr_q;
    d_ptr_d    = d_ptr_q;
    plane_d    = plane_q;
    grp_d      = grp_q;
    groups_d   = groups_q;
    pict_d     = pict_q;
    wdog_d     = wdog_q;
    fin_prev_d = conv_finish_in;
    err_d      = err_q;
    tag_d      = tag_q;
    waddr_d    = waddr_q;
    daddr_d    = daddr_q;
    pict_out_d = pict_out_q;
    first_d    = first_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          w_ptr_d  = cmd_weight_base;
          d_ptr_d  = cmd_data_base;
          pict_d   = cmd_pict_size;
          groups_d = cmd_groups;
          grp_d    = '0;
          err_d    = 1'b0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        plane_d = AddrWidth'(pict_q) * AddrWidth'(pict_q);
        grp_d   = '0;
        if (groups_q == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        for (int n = 0; n < 4; n++) begin
          waddr_d[n] = w_ptr_q + AddrWidth'(n * KernelSize);
          daddr_d[n] = d_ptr_q + AddrWidth'(n) * plane_q;
        end
        first_d    = (grp_q == '0);
        last_d     = last_grp;
        pict_out_d = pict_q;
        tag_d      = ~tag_q;
        wdog_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (fin_rise) begin
          state_d = S_NEXT;
        end else if (wdog_inc == '1) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_NEXT: begin
        if (last_grp) begin
          state_d = S_DONE;
        end else begin
          grp_d   = grp_q + GroupWidth'(1);
          w_ptr_d = w_ptr_q + AddrWidth'(KernelSize * InputDim);
          d_ptr_d = d_ptr_q + AddrWidth'(InputDim) * plane_q;
          state_d = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any layer and clears the tag
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      w_ptr_q    <= '0;
      d_ptr_q    <= '0;
      plane_q    <= '0;
      grp_q      <= '0;
      groups_q   <= '0;
      pict_q     <= '0;
      wdog_q     <= '0;
      fin_prev_q <= 1'b0;
      err_q      <= 1'b0;
      tag_q      <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        waddr_q[n] <= '0;
        daddr_q[n] <= '0;
      end
      pict_out_q <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_ptr_q    <= w_ptr_d;
      d_ptr_q    <= d_ptr_d;
      plane_q    <= plane_d;
      grp_q      <= grp_d;
      groups_q   <= groups_d;
      pict_q     <= pict_d;
      wdog_q     <= wdog_d;
      fin_prev_q <= fin_prev_d;
      err_q      <= err_d;
      tag_q      <= tag_d;
      waddr_q    <= waddr_d;
      daddr_q    <= daddr_d;
      pict_out_q <= pict_out_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign err              = err_q;
  assign inst_tag_out     = tag_q;
  assign weight_addr0_out = waddr_q[0];
  assign weight_addr1_out = waddr_q[1];
  assign weight_addr2_out = waddr_q[2];
  assign weight_addr3_out = waddr_q[3];
  assign data_addr0_out   = daddr_q[0];
  assign data_addr1_out   = daddr_q[1];
  assign data_addr2_out   = daddr_q[2];
  assign data_addr3_out   = daddr_q[3];
  assign pict_size_out    = pict_out_q;
  assign conv_first_out   = first_q;
  assign conv_last_out    = last_q;

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - randomized directed bench for conv_sched against a layer-level model
module tb_conv_sched;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_weight_base = '0;
  logic [31:0] cmd_data_base = '0;
  logic [8:0]  cmd_pict_size = '0;
  logic [7:0]  cmd_groups = '0;
  logic        conv_finish_in = 1'b0;
  logic [31:0] weight_addr0_out, weight_addr1_out, weight_addr2_out, weight_addr3_out;
  logic [31:0] data_addr0_out, data_addr1_out, data_addr2_out, data_addr3_out;
  logic [8:0]  pict_size_out;
  logic        conv_first_out, conv_last_out, inst_tag_out, busy, done, err;

  logic [31:0] wa [4];
  logic [31:0] da [4];
  assign wa[0] = weight_addr0_out;
  assign wa[1] = weight_addr1_out;
  assign wa[2] = weight_addr2_out;
  assign wa[3] = weight_addr3_out;
  assign da[0] = data_addr0_out;
  assign da[1] = data_addr1_out;
  assign da[2] = data_addr2_out;
  assign da[3] = data_addr3_out;

  int   total = 0;
  int   bad = 0;
  logic exp_tag = 1'b0;

  conv_sched #(
    .AddrWidth(32), .PictWidth(9), .GroupWidth(8),
    .KernelSize(9), .InputDim(4), .TimeoutWidth(4)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_weight_base(cmd_weight_base), .cmd_data_base(cmd_data_base),
    .cmd_pict_size(cmd_pict_size), .cmd_groups(cmd_groups),
    .conv_finish_in(conv_finish_in),
    .weight_addr0_out(weight_addr0_out), .weight_addr1_out(weight_addr1_out),
    .weight_addr2_out(weight_addr2_out), .weight_addr3_out(weight_addr3_out),
    .data_addr0_out(data_addr0_out), .data_addr1_out(data_addr1_out),
    .data_addr2_out(data_addr2_out), .data_addr3_out(data_addr3_out),
    .pict_size_out(pict_size_out),
    .conv_first_out(conv_first_out), .conv_last_out(conv_last_out),
    .inst_tag_out(inst_tag_out), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one layer; hold_n/low_n < 0 picks random finish timing per instruction.
  task automatic run_layer(input logic [31:0] wb, input logic [31:0] db, input logic [8:0] p,
                           input logic [7:0] g, input int hold_n, input int low_n);
    logic [31:0] plane;
    int h, l;
    plane = 32'(p) * 32'(p);
    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_weight_base = wb;
    cmd_data_base = db;
    cmd_pict_size = p;
    cmd_groups = g;
    tick();
    cmd_valid = 1'b0;
    cmd_weight_base = $urandom;
    cmd_data_base = $urandom;
    cmd_pict_size = 9'($urandom);
    cmd_groups = 8'($urandom);
    chk("busy_setup", 32'(busy), 1);
    chk("ready_busy", 32'(cmd_ready), 0);
    if (g == 0) begin
      tick();
      chk("zero_done", 32'(done), 1);
      chk("zero_err", 32'(err), 1);
      chk("zero_tag", 32'(inst_tag_out), 32'(exp_tag));
      tick();
      chk("zero_done_end", 32'(done), 0);
      chk("zero_ready", 32'(cmd_ready), 1);
      chk("zero_err_hold", 32'(err), 1);
      return;
    end
    for (int gi = 0; gi < int'(g); gi++) begin
      tick();
      tick();
      exp_tag = ~exp_tag;
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("waddr%0d_g%0d", n, gi), wa[n], wb + 32'(gi * 36 + n * 9));
        chk($sformatf("daddr%0d_g%0d", n, gi), da[n], db + 32'(gi * 4 + n) * plane);
      end
      chk("first", 32'(conv_first_out), 32'(gi == 0));
      chk("last", 32'(conv_last_out), 32'(gi == int'(g) - 1));
      chk("pict", 32'(pict_size_out), 32'(p));
      chk("tag_issue", 32'(inst_tag_out), 32'(exp_tag));
      h = (hold_n < 0) ? int'($urandom_range(0, 3)) : hold_n;
      l = (low_n < 0) ? int'($urandom_range(1, 5)) : low_n;
      repeat (h) begin
        tick();
        chk("tag_hold", 32'(inst_tag_out), 32'(exp_tag));
        chk("done_hold", 32'(done), 0);
      end
      conv_finish_in = 1'b0;
      cmd_valid = 1'b1;
      repeat (l) begin
        tick();
        chk("tag_low", 32'(inst_tag_out), 32'(exp_tag));
        chk("ready_wait", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      conv_finish_in = 1'b1;
      tick();
    end
    tick();
    chk("layer_done", 32'(done), 1);
    chk("layer_err", 32'(err), 0);
    tick();
    chk("done_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("ready_end", 32'(cmd_ready), 1);
  endtask

  initial begin
    int cnt;
    // reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_tag", 32'(inst_tag_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_waddr0", weight_addr0_out, 0);
    chk("rst_daddr3", data_addr3_out, 0);
    Rst_n = 1'b1;
    tick();

    // directed layer: second instruction sees finish held high, 5 low cycles, then raise
    run_layer(32'h100, 32'h1000, 9'd8, 8'd2, 3, 5);
    chk("tag_two_toggles", 32'(inst_tag_out), 0);

    // zero groups
    run_layer(32'h200, 32'h2000, 9'd3, 8'd0, 0, 1);

    // address wrap
    run_layer(32'h1234, 32'hFFFF_FFF0, 9'd4, 8'd1, 0, 1);
    chk("wrap_daddr1", data_addr1_out, 32'h0);

    // watchdog timeout
    conv_finish_in = 1'b0;
    tick();
    cmd_valid = 1'b1;
    cmd_weight_base = 32'h40;
    cmd_data_base = 32'h80;
    cmd_pict_size = 9'd2;
    cmd_groups = 8'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    exp_tag = ~exp_tag;
    chk("to_tag", 32'(inst_tag_out), 32'(exp_tag));
    cnt = 0;
    while (!done && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 15);
    chk("to_err", 32'(err), 1);
    tick();
    chk("to_ready", 32'(cmd_ready), 1);
    chk("to_err_hold", 32'(err), 1);

    // reset mid-WAIT
    cmd_valid = 1'b1;
    cmd_groups = 8'd2;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    #2;
    Rst_n = 1'b0;
    #1;
    exp_tag = 1'b0;
    chk("mid_rst_tag", 32'(inst_tag_out), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_waddr0", weight_addr0_out, 0);
    chk("mid_rst_first", 32'(conv_first_out), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    tick();
    Rst_n = 1'b1;
    tick();

    // randomized layers
    for (int k = 0; k < 6; k++) begin
      run_layer($urandom, $urandom, 9'($urandom_range(1, 511)), 8'($urandom_range(1, 4)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
